// File: rtl/strided_read_engine.sv
// Cache-line read request generator: linear, strided or repeating address runs,
// bounded by an in-flight read limit, with a two-stage registered issue pipeline.
module strided_read_engine #(
  parameter int         ADDR_W          = 42,
  parameter int         MDATA_W         = 16,
  parameter int         MAX_OUTSTANDING = 64,
  parameter logic [3:0] RUN_TAG         = 4'hA
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                base_addr,
  input  logic [31:0]                      num_cls,
  input  logic [15:0]                      stride,
  input  logic [1:0]                       mode,
  input  logic                             abort,
  input  logic                             stall,
  input  logic                             rd_rsp_valid,
  output logic                             rd_valid,
  output logic [ADDR_W-1:0]                rd_addr,
  output logic [MDATA_W-1:0]               rd_mdata,
  output logic                             busy,
  output logic                             run_done,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             rsp_err,
  output logic [1:0]                       dbg_state
);
  localparam int CW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int IDX_W = MDATA_W - 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] M_STRIDED = 2'd1;
  localparam logic [1:0] M_REPEAT  = 2'd2;

  localparam logic [CW:0] MAX_C = (CW+1)'(MAX_OUTSTANDING);

  // rd_valid is a one-cycle request strobe with no ready: the consumer must take it.
  // stall is the only back-pressure and gates the issue decision, two cycles ahead of rd_valid.

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [31:0]        num_q, num_d;
  logic [15:0]        stride_q, stride_d;
  logic [1:0]         mode_q, mode_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               s1_v_q, s1_v_d;
  logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d;
  logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;
  logic               rdv_q, rdv_d;
  logic [ADDR_W-1:0]  rda_q, rda_d;
  logic [MDATA_W-1:0] rdm_q, rdm_d;
  logic [CW-1:0]      out_q, out_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic              issue;
  logic              last_in_pass;
  logic [CW:0]       inflight;
  logic [ADDR_W-1:0] addr_inc;

  // Requests still in the pipeline count against the limit before they reach outstanding.
  assign inflight     = {1'b0, out_q} + (CW+1)'(s1_v_q) + (CW+1)'(rdv_q);
  assign last_in_pass = (cnt_q == num_q - 32'd1);
  assign addr_inc     = (mode_q == M_STRIDED) ? ADDR_W'(stride_q) : ADDR_W'(1);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    num_d    = num_q;
    stride_d = stride_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    issue    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base_addr;
          num_d    = num_cls;
          stride_d = stride;
          mode_d   = mode;
          addr_d   = base_addr;
          cnt_d    = '0;
          idx_d    = '0;
          state_d  = (num_cls == 32'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = DRAIN;
        end else if (!stall && (inflight < MAX_C)) begin
          issue = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          if (last_in_pass && (mode_q == M_REPEAT)) begin
            addr_d = base_q;
            cnt_d  = '0;
          end else begin
            addr_d = addr_q + addr_inc;
            cnt_d  = cnt_q + 32'd1;
          end
          if (last_in_pass && (mode_q != M_REPEAT)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_v_q && !rdv_q && (out_q == '0)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s1_v_d    = issue;
    s1_addr_d = issue ? addr_q : s1_addr_q;
    s1_idx_d  = issue ? idx_q : s1_idx_q;
    rdv_d     = s1_v_q;
    rda_d     = s1_v_q ? s1_addr_q : rda_q;
    rdm_d     = s1_v_q ? {RUN_TAG, s1_idx_q} : rdm_q;
    done_d    = (state_q == DONE);
  end

  // A response with nothing in flight is an error; the count saturates at zero.
  always_comb begin
    out_d = out_q;
    err_d = err_q;
    if (start && (state_q == IDLE)) err_d = 1'b0;
    case ({rdv_q, rd_rsp_valid})
      2'b10: out_d = out_q + CW'(1);
      2'b01: begin
        if (out_q == '0) err_d = 1'b1;
        else             out_d = out_q - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      num_q     <= '0;
      stride_q  <= '0;
      mode_q    <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      s1_v_q    <= 1'b0;
      s1_addr_q <= '0;
      s1_idx_q  <= '0;
      rdv_q     <= 1'b0;
      rda_q     <= '0;
      rdm_q     <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      num_q     <= num_d;
      stride_q  <= stride_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      s1_v_q    <= s1_v_d;
      s1_addr_q <= s1_addr_d;
      s1_idx_q  <= s1_idx_d;
      rdv_q     <= rdv_d;
      rda_q     <= rda_d;
      rdm_q     <= rdm_d;
      out_q     <= out_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign rd_valid    = rdv_q;
  assign rd_addr     = rda_q;
  assign rd_mdata    = rdm_q;
  assign busy        = (state_q != IDLE);
  assign run_done    = done_q;
  assign outstanding = out_q;
  assign rsp_err     = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_strided_read_engine.sv
// Directed bench for strided_read_engine: expected request stream and in-flight
// count come from a simple arithmetic model; scenario results are pinned by literals.
module tb_strided_read_engine;
  localparam int EXP_W = 58;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [41:0] base_addr;
  logic [31:0] num_cls;
  logic [15:0] stride;
  logic [1:0]  mode;
  logic        abort;
  logic        stall;
  logic        rd_rsp_valid;
  logic        rd_valid;
  logic [41:0] rd_addr;
  logic [15:0] rd_mdata;
  logic        busy;
  logic        run_done;
  logic [2:0]  outstanding;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  strided_read_engine #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_cls(num_cls), .stride(stride), .mode(mode), .abort(abort),
    .stall(stall), .rd_rsp_valid(rd_rsp_valid), .rd_valid(rd_valid),
    .rd_addr(rd_addr), .rd_mdata(rd_mdata), .busy(busy), .run_done(run_done),
    .outstanding(outstanding), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [41:0]      log_addr[$];
  logic [15:0]      log_md[$];
  int               rsp_sched[$];
  logic [EXP_W-1:0] e;
  int n_checks = 0, n_fail = 0;
  int exp_out = 0;
  logic exp_err = 1'b0;
  int rv_count = 0, done_count = 0, done_cyc = -1, first_rv_cyc = -1, peak_out = 0;
  int start_cyc = 0;
  int win_lo = 1000000000, win_hi = 1000000000, rv_win = 0;
  int win2_lo = 1000000000, rv_win2 = 0;
  int rv_mid_lo = 1000000000, rv_mid_hi = 1000000000, rv_mid = 0;
  bit rsp_auto = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (reset_n) begin
      check("outstanding", 64'(outstanding), 64'(exp_out));
      check("rsp_err", 64'(rsp_err), 64'(exp_err));
      if (rd_valid) begin
        rv_count++;
        if (first_rv_cyc < 0) first_rv_cyc = cyc;
        if (cyc >= win_lo && cyc <= win_hi) rv_win++;
        if (cyc >= win2_lo) rv_win2++;
        if (cyc >= rv_mid_lo && cyc <= rv_mid_hi) rv_mid++;
        log_addr.push_back(rd_addr);
        log_md.push_back(rd_mdata);
        if (rsp_auto) rsp_sched.push_back(cyc + 5);
        check("rd_valid_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rd_addr", 64'(rd_addr), 64'(e[57:16]));
          check("rd_mdata", 64'(rd_mdata), 64'(e[15:0]));
        end
      end
      if (run_done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (int'(outstanding) > peak_out) peak_out = int'(outstanding);
      // In-flight model: requests accepted minus responses, never below zero.
      if (start && !busy) exp_err = 1'b0;
      if (rd_valid && !rd_rsp_valid) exp_out++;
      else if (!rd_valid && rd_rsp_valid) begin
        if (exp_out == 0) exp_err = 1'b1;
        else exp_out--;
      end
    end
  end

  // Automatic responder: one response a fixed latency after each request.
  always @(posedge clk) begin
    #1;
    if (rsp_auto) begin
      if (rsp_sched.size() != 0 && rsp_sched[0] <= cyc) begin
        void'(rsp_sched.pop_front());
        rd_rsp_valid = 1'b1;
      end else begin
        rd_rsp_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [41:0] b, input int n, input logic [15:0] s,
                          input logic [1:0] m, input int count);
    logic [63:0] a;
    logic [41:0] a42;
    logic [15:0] md;
    for (int i = 0; i < count; i++) begin
      if (m == 2'd1)      a = 64'(b) + 64'(i) * 64'(s);
      else if (m == 2'd2) a = 64'(b) + 64'(i % n);
      else                a = 64'(b) + 64'(i);
      a42 = a[41:0];
      md  = 16'hA000 | 16'(i % 4096);
      exp_q.push_back({a42, md});
    end
  endtask

  task automatic clear_run();
    log_addr.delete();
    log_md.delete();
    rv_count = 0;
    first_rv_cyc = -1;
    peak_out = 0;
  endtask

  task automatic run_start(input logic [41:0] b, input logic [31:0] n,
                           input logic [15:0] s, input logic [1:0] m);
    @(posedge clk); #1;
    base_addr = b; num_cls = n; stride = s; mode = m; start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_rsp();
    @(posedge clk); #1; rd_rsp_valid = 1'b1;
    @(posedge clk); #1; rd_rsp_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_count;
    n = 0;
    while (done_count == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("run_done_within_budget", 64'(done_count != d0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int s_c;
    int a_c;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; num_cls = '0; stride = '0;
    mode = '0; abort = 1'b0; stall = 1'b0; rd_rsp_valid = 1'b0;
    wait_cycles(3);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_outstanding", 64'(outstanding), 64'd0);
    check("reset_run_done", 64'(run_done), 64'd0);
    check("reset_rd_addr", 64'(rd_addr), 64'd0);

    // Linear run, responses 5 cycles after each request.
    rsp_auto = 1'b1;
    clear_run();
    push_exp(42'h100, 4, 16'd0, 2'd0, 4);
    d0 = done_count;
    run_start(42'h100, 32'd4, 16'd0, 2'd0);
    wait_done(200);
    wait_cycles(5);
    check("lin_done_pulses", 64'(done_count - d0), 64'd1);
    check("lin_first_latency", 64'(first_rv_cyc - start_cyc), 64'd3);
    check("lin_peak_outstanding", 64'(peak_out), 64'd4);
    check("lin_addr0", 64'(log_addr[0]), 64'h100);
    check("lin_addr3", 64'(log_addr[3]), 64'h103);
    check("lin_md0", 64'(log_md[0]), 64'hA000);
    check("lin_md3", 64'(log_md[3]), 64'hA003);
    check("lin_count", 64'(rv_count), 64'd4);
    check("lin_busy_end", 64'(busy), 64'd0);

    // Strided run wrapping past the top of the address space.
    clear_run();
    push_exp(42'h3FF_FFFF_FFFE, 3, 16'd3, 2'd1, 3);
    run_start(42'h3FF_FFFF_FFFE, 32'd3, 16'd3, 2'd1);
    wait_done(200);
    wait_cycles(3);
    check("str_addr0", 64'(log_addr[0]), 64'h3FF_FFFF_FFFE);
    check("str_addr1", 64'(log_addr[1]), 64'h001);
    check("str_addr2", 64'(log_addr[2]), 64'h004);
    check("str_queue_empty", 64'(exp_q.size()), 64'd0);

    // In-flight limit of 4 with responses withheld.
    rsp_auto = 1'b0;
    rd_rsp_valid = 1'b0;
    clear_run();
    push_exp(42'h800, 10, 16'd0, 2'd0, 10);
    d0 = done_count;
    run_start(42'h800, 32'd10, 16'd0, 2'd0);
    wait_cycles(25);
    check("lim_initial_issues", 64'(rv_count), 64'd4);
    for (int k = 1; k <= 6; k++) begin
      send_rsp();
      wait_cycles(8);
      check("lim_one_per_rsp", 64'(rv_count), 64'(4 + k));
    end
    for (int k = 7; k <= 9; k++) begin
      send_rsp();
      wait_cycles(4);
      check("lim_no_early_done", 64'(done_count - d0), 64'd0);
    end
    send_rsp();
    wait_done(20);
    check("lim_total_issues", 64'(rv_count), 64'd10);

    // Repeat mode with a stall window, then abort.
    rsp_auto = 1'b1;
    clear_run();
    push_exp(42'h200, 2, 16'd0, 2'd2, 64);
    d0 = done_count;
    run_start(42'h200, 32'd2, 16'd0, 2'd2);
    wait_cycles(6);
    @(posedge clk); #1;
    stall = 1'b1;
    s_c = cyc;
    win_lo = s_c + 2;
    win_hi = s_c + 6;
    rv_mid_lo = s_c + 7;
    repeat (5) @(posedge clk);
    #1 stall = 1'b0;
    wait_cycles(6);
    @(posedge clk); #1;
    abort = 1'b1;
    a_c = cyc;
    rv_mid_hi = a_c + 1;
    win2_lo = a_c + 2;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(100);
    wait_cycles(3);
    check("rep_no_issue_in_stall", 64'(rv_win), 64'd0);
    check("rep_resumed_after_stall", 64'(rv_mid > 0), 64'd1);
    check("rep_no_issue_after_abort", 64'(rv_win2), 64'd0);
    check("rep_done_pulses", 64'(done_count - d0), 64'd1);
    check("rep_addr0", 64'(log_addr[0]), 64'h200);
    check("rep_addr1", 64'(log_addr[1]), 64'h201);
    check("rep_addr2", 64'(log_addr[2]), 64'h200);
    check("rep_md2", 64'(log_md[2]), 64'hA002);
    exp_q.delete();
    win_lo = 1000000000; win2_lo = 1000000000; rv_mid_lo = 1000000000;

    // Reset during DRAIN with three reads in flight.
    rsp_auto = 1'b0;
    rd_rsp_valid = 1'b0;
    clear_run();
    push_exp(42'h40, 3, 16'd0, 2'd0, 3);
    run_start(42'h40, 32'd3, 16'd0, 2'd0);
    wait_cycles(10);
    @(negedge clk);
    check("rst_pre_outstanding", 64'(outstanding), 64'd3);
    check("rst_pre_drain", 64'(dbg_state), 64'd2);
    d0 = done_count;
    @(posedge clk); #3;
    reset_n = 1'b0;
    exp_out = 0;
    exp_err = 1'b0;
    exp_q.delete();
    #1;
    check("rst_async_outstanding", 64'(outstanding), 64'd0);
    check("rst_async_busy", 64'(busy), 64'd0);
    check("rst_async_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_async_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_async_rd_mdata", 64'(rd_mdata), 64'd0);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("rst_idle_state", 64'(dbg_state), 64'd0);
    check("rst_idle_busy", 64'(busy), 64'd0);
    send_rsp();
    @(negedge clk);
    check("rst_rsp_err_set", 64'(rsp_err), 64'd1);
    wait_cycles(10);
    check("rst_no_run_done", 64'(done_count - d0), 64'd0);

    // Zero-length run: no requests, run_done two cycles after start, rsp_err cleared.
    clear_run();
    d0 = done_count;
    run_start(42'h500, 32'd0, 16'd0, 2'd0);
    wait_done(20);
    wait_cycles(5);
    check("zero_no_rd_valid", 64'(rv_count), 64'd0);
    check("zero_done_latency", 64'(done_cyc - start_cyc), 64'd2);
    check("zero_done_pulses", 64'(done_count - d0), 64'd1);
    check("zero_rsp_err_cleared", 64'(rsp_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
